// File: rtl/pkt_store_pkg.sv
// Shared packet-store definitions: sizing, writer FSM states and the descriptor record.
package pkt_store_pkg;

  localparam int unsigned NUM_SLOTS = 1024;
  localparam int unsigned SLOT_W    = 10;
  localparam int unsigned MAX_LEN   = 1024;
  localparam int unsigned BYTE_W    = 10;
  localparam int unsigned LEN_W     = 11;
  localparam int unsigned DROP_W    = 16;

  typedef enum logic [1:0] {
    StIdle,
    StWrite,
    StDrop,
    StCommit
  } wr_state_e;

  typedef struct packed {
    logic [SLOT_W-1:0] slot;
    logic [LEN_W-1:0]  len;
  } pkt_desc_t;

endpackage

// File: rtl/pkt_slot_tracker.sv
// Ring-order slot allocator: next write slot and count of committed, unreleased slots.
module pkt_slot_tracker
  import pkt_store_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              commit,
  input  logic              rel,
  output logic [SLOT_W-1:0] wr_slot,
  output logic [LEN_W-1:0]  used_count,
  output logic              full
);

  logic rel_eff;

  // A release with nothing occupied is meaningless and must not underflow.
  assign rel_eff = rel && (used_count != '0);
  assign full    = (used_count == LEN_W'(NUM_SLOTS));

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_slot    <= '0;
      used_count <= '0;
    end else begin
      if (commit) begin
        wr_slot <= (wr_slot == SLOT_W'(NUM_SLOTS - 1)) ? '0 : wr_slot + 1'b1;
      end
      if (commit && !rel_eff) begin
        used_count <= used_count + 1'b1;
      end else if (!commit && rel_eff) begin
        used_count <= used_count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/pkt_ingress_writer.sv
// Writes framed byte packets into ring-ordered RAM slots and emits a (slot, len) descriptor.
module pkt_ingress_writer
  import pkt_store_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [7:0]        ram_data,
  output logic [SLOT_W-1:0] ram_addr,
  output logic [BYTE_W-1:0] ram_byte,
  output logic              ram_we,
  output logic              desc_valid,
  input  logic              desc_ready,
  output logic [SLOT_W-1:0] desc_slot,
  output logic [LEN_W-1:0]  desc_len,
  input  logic              rel,
  output logic [LEN_W-1:0]  used_count,
  output logic [DROP_W-1:0] drop_count
);

  wr_state_e         state;
  logic [LEN_W-1:0]  byte_cnt;
  pkt_desc_t         desc_q;
  logic [SLOT_W-1:0] wr_slot;
  logic              full;
  logic              accept;
  logic              commit;

  pkt_slot_tracker u_slot_tracker (
    .clk        (clk),
    .rst        (rst),
    .commit     (commit),
    .rel        (rel),
    .wr_slot    (wr_slot),
    .used_count (used_count),
    .full       (full)
  );

  always_comb begin
    in_ready = 1'b0;
    if (!rst) begin
      unique case (state)
        StIdle:          in_ready = !full;
        StWrite, StDrop: in_ready = 1'b1;
        StCommit:        in_ready = 1'b0;
      endcase
    end
  end

  assign accept = in_valid && in_ready;
  // A descriptor may be loaded when the output register is empty or being drained this cycle.
  assign commit = (state == StCommit) && (!desc_valid || desc_ready);

  assign desc_slot = desc_q.slot;
  assign desc_len  = desc_q.len;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= StIdle;
      byte_cnt   <= '0;
      drop_count <= '0;
      desc_valid <= 1'b0;
      desc_q     <= '0;
      ram_we     <= 1'b0;
      ram_data   <= '0;
      ram_addr   <= '0;
      ram_byte   <= '0;
    end else begin
      ram_we <= 1'b0;
      if (desc_valid && desc_ready) begin
        desc_valid <= 1'b0;
      end
      unique case (state)
        StIdle: begin
          if (accept) begin
            ram_we   <= 1'b1;
            ram_addr <= wr_slot;
            ram_byte <= '0;
            ram_data <= in_data;
            byte_cnt <= LEN_W'(1);
            state    <= in_last ? StCommit : StWrite;
          end
        end
        StWrite: begin
          if (accept) begin
            if (byte_cnt == LEN_W'(MAX_LEN)) begin
              // Oversize: the slot is left uncommitted and reused by the next packet.
              if (drop_count != {DROP_W{1'b1}}) begin
                drop_count <= drop_count + 1'b1;
              end
              state <= in_last ? StIdle : StDrop;
            end else begin
              ram_we   <= 1'b1;
              ram_addr <= wr_slot;
              ram_byte <= byte_cnt[BYTE_W-1:0];
              ram_data <= in_data;
              byte_cnt <= byte_cnt + 1'b1;
              if (in_last) begin
                state <= StCommit;
              end
            end
          end
        end
        StDrop: begin
          if (accept && in_last) begin
            state <= StIdle;
          end
        end
        StCommit: begin
          if (commit) begin
            desc_valid  <= 1'b1;
            desc_q.slot <= wr_slot;
            desc_q.len  <= byte_cnt;
            state       <= StIdle;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pkt_ingress_writer.sv
// Self-checking bench for pkt_ingress_writer: packet-level reference model plus directed sequences.
module tb_pkt_ingress_writer;
  import pkt_store_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [7:0]        in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_last = 1'b0;
  logic              in_ready;
  logic [7:0]        ram_data;
  logic [SLOT_W-1:0] ram_addr;
  logic [BYTE_W-1:0] ram_byte;
  logic              ram_we;
  logic              desc_valid;
  logic              desc_ready = 1'b0;
  logic [SLOT_W-1:0] desc_slot;
  logic [LEN_W-1:0]  desc_len;
  logic              rel = 1'b0;
  logic [LEN_W-1:0]  used_count;
  logic [DROP_W-1:0] drop_count;

  pkt_ingress_writer dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .ram_data   (ram_data),
    .ram_addr   (ram_addr),
    .ram_byte   (ram_byte),
    .ram_we     (ram_we),
    .desc_valid (desc_valid),
    .desc_ready (desc_ready),
    .desc_slot  (desc_slot),
    .desc_len   (desc_len),
    .rel        (rel),
    .used_count (used_count),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [SLOT_W-1:0] slot;
    logic [BYTE_W-1:0] idx;
    logic [7:0]        data;
  } wr_t;

  typedef struct packed {
    logic [SLOT_W-1:0] slot;
    logic [LEN_W-1:0]  len;
  } dsc_t;

  typedef struct {
    int len;
    int exp_len;   // 0: packet must be dropped
    int exp_slot;
    int exp_drops;
  } vec_t;

  wr_t  exp_wr[$];
  dsc_t exp_desc[$];
  int   m_len, m_slot, m_drops, handed, rel_applied, desc_seen;
  bit   m_dropping;
  int   last_slot, last_len;
  int   n_checks = 0;
  int   n_pass = 0;
  bit   rnd_done;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Packet-level model: every accepted byte of a packet up to MAX_LEN lands at (slot, index);
  // a packet reaching its last byte in range yields a descriptor and advances the ring slot.
  task automatic model_byte(input logic [7:0] d, input logic l);
    if (m_dropping) begin
      if (l) m_dropping = 1'b0;
    end else if (m_len < int'(MAX_LEN)) begin
      exp_wr.push_back('{slot: SLOT_W'(m_slot), idx: BYTE_W'(m_len), data: d});
      m_len++;
      if (l) begin
        exp_desc.push_back('{slot: SLOT_W'(m_slot), len: LEN_W'(m_len)});
        m_slot = (m_slot + 1) % int'(NUM_SLOTS);
        m_len  = 0;
      end
    end else begin
      if (m_drops < 65535) m_drops++;
      m_len      = 0;
      m_dropping = !l;
    end
  endtask

  always @(negedge clk) begin
    int   exp_used;
    wr_t  w;
    dsc_t d;
    if (rst) begin
      exp_wr.delete();
      exp_desc.delete();
      m_len = 0; m_slot = 0; m_drops = 0; m_dropping = 1'b0;
      handed = 0; rel_applied = 0;
    end else begin
      if (ram_we) begin
        if (exp_wr.size() == 0) chk("ram_we_unexpected", 1, 0);
        else begin
          w = exp_wr.pop_front();
          chk("ram_write", {ram_addr, ram_byte, ram_data}, longint'(w));
        end
      end
      exp_used = handed + int'(desc_valid) - rel_applied;
      chk("used_count", used_count, exp_used);
      chk("drop_count", drop_count, m_drops);
      if (desc_valid && desc_ready) begin
        if (exp_desc.size() == 0) chk("desc_unexpected", 1, 0);
        else begin
          d = exp_desc.pop_front();
          chk("desc", {desc_slot, desc_len}, longint'(d));
        end
        handed++;
        desc_seen++;
        last_slot = int'(desc_slot);
        last_len  = int'(desc_len);
      end
      if (rel && exp_used > 0) rel_applied++;
      if (in_valid && in_ready) model_byte(in_data, in_last);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; rel = 1'b0;
    @(negedge clk);
    chk("in_ready_during_reset", in_ready, 0);
    tick();
    rst = 1'b0;
  endtask

  task automatic check_reset_vals();
    chk("rst_desc_valid", desc_valid, 0);
    chk("rst_desc_slot", desc_slot, 0);
    chk("rst_desc_len", desc_len, 0);
    chk("rst_used", used_count, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_ram", {ram_we, ram_addr, ram_byte, ram_data}, 0);
    chk("rst_in_ready", in_ready, 1);
  endtask

  // Returns #1 after the edge on which the byte was accepted.
  task automatic send_byte(input logic [7:0] d, input logic l);
    int n = 0;
    in_data = d; in_last = l; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 3000) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_pkt(input int len, input bit gaps);
    for (int i = 0; i < len; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) tick();
      send_byte(8'($urandom), i == len - 1);
    end
  endtask

  vec_t tbl[7];

  initial begin
    int seen0;

    tbl[0] = '{1024, 1024, 0, 0};
    tbl[1] = '{1025, 0,    0, 1};
    tbl[2] = '{1,    1,    1, 1};
    tbl[3] = '{3,    3,    2, 1};
    tbl[4] = '{2000, 0,    0, 2};
    tbl[5] = '{1,    1,    3, 2};
    tbl[6] = '{7,    7,    4, 2};

    // Reset state and the 3-byte timing sequence.
    do_reset();
    check_reset_vals();
    desc_ready = 1'b1;
    send_byte(8'hA1, 1'b0);
    chk("p3_w0", {ram_we, ram_addr, ram_byte, ram_data}, {1'b1, 10'd0, 10'd0, 8'hA1});
    send_byte(8'hA2, 1'b0);
    chk("p3_w1", {ram_we, ram_addr, ram_byte, ram_data}, {1'b1, 10'd0, 10'd1, 8'hA2});
    send_byte(8'hA3, 1'b1);
    chk("p3_w2", {ram_we, ram_addr, ram_byte, ram_data}, {1'b1, 10'd0, 10'd2, 8'hA3});
    chk("p3_commit_not_ready", in_ready, 0);
    chk("p3_desc_not_yet", desc_valid, 0);
    tick();
    chk("p3_ram_idle", ram_we, 0);
    chk("p3_desc", {desc_valid, desc_slot, desc_len}, {1'b1, 10'd0, 11'd3});
    chk("p3_used", used_count, 1);
    tick();

    // Table of whole packets, each checked by its final descriptor and drop count.
    do_reset();
    desc_ready = 1'b1;
    foreach (tbl[i]) begin
      seen0 = desc_seen;
      send_pkt(tbl[i].len, 1'b0);
      repeat (4) tick();
      if (tbl[i].exp_len == 0) begin
        chk($sformatf("tbl%0d_no_desc", i), desc_seen - seen0, 0);
      end else begin
        chk($sformatf("tbl%0d_ndesc", i), desc_seen - seen0, 1);
        chk($sformatf("tbl%0d_slot", i), last_slot, tbl[i].exp_slot);
        chk($sformatf("tbl%0d_len", i), last_len, tbl[i].exp_len);
      end
      chk($sformatf("tbl%0d_drops", i), drop_count, tbl[i].exp_drops);
    end

    // Reset in the middle of a packet abandons it and restarts at slot 0.
    for (int i = 0; i < 10; i++) send_byte(8'(i), 1'b0);
    do_reset();
    check_reset_vals();
    send_byte(8'h5A, 1'b1);
    chk("mid_rst_w0", {ram_we, ram_addr, ram_byte, ram_data}, {1'b1, 10'd0, 10'd0, 8'h5A});
    repeat (3) tick();

    // Descriptor backpressure across two packets.
    do_reset();
    desc_ready = 1'b0;
    send_pkt(2, 1'b0);
    send_pkt(2, 1'b0);
    repeat (3) tick();
    chk("bp_hold_ready", in_ready, 0);
    chk("bp_first", {desc_valid, desc_slot, desc_len}, {1'b1, 10'd0, 11'd2});
    desc_ready = 1'b1;
    tick();
    chk("bp_second", {desc_valid, desc_slot, desc_len}, {1'b1, 10'd1, 11'd2});
    chk("bp_ready_again", in_ready, 1);
    tick();
    chk("bp_drained", desc_valid, 0);

    // Commit coinciding with rel, then rel at zero occupancy.
    do_reset();
    desc_ready = 1'b1;
    repeat (5) send_pkt(1, 1'b0);
    repeat (3) tick();
    chk("cr_used5", used_count, 5);
    send_byte(8'h33, 1'b1);
    rel = 1'b1;
    tick();
    rel = 1'b0;
    chk("cr_commit_rel", used_count, 5);
    chk("cr_slot", desc_slot, 5);
    rel = 1'b1;
    repeat (5) tick();
    rel = 1'b0;
    chk("cr_used0", used_count, 0);
    rel = 1'b1;
    tick();
    rel = 1'b0;
    chk("cr_rel_at_zero", used_count, 0);

    // Fill every slot, observe back-pressure, free one, wrap to slot 0.
    do_reset();
    desc_ready = 1'b1;
    for (int i = 0; i < int'(NUM_SLOTS); i++) send_byte(8'(i), 1'b1);
    repeat (3) tick();
    chk("full_used", used_count, NUM_SLOTS);
    in_valid = 1'b1; in_last = 1'b1;
    repeat (4) tick();
    chk("full_in_ready", in_ready, 0);
    in_valid = 1'b0;
    rel = 1'b1;
    tick();
    rel = 1'b0;
    chk("full_rel_ready", in_ready, 1);
    chk("full_rel_used", used_count, NUM_SLOTS - 1);
    send_byte(8'hEE, 1'b1);
    repeat (3) tick();
    chk("wrap_slot", last_slot, 0);
    chk("wrap_len", last_len, 1);

    // Randomized traffic against the reference model.
    do_reset();
    rnd_done = 1'b0;
    fork
      begin
        for (int p = 0; p < 40; p++) begin
          if ($urandom_range(0, 7) == 0) send_pkt($urandom_range(1020, 1030), 1'b1);
          else send_pkt($urandom_range(1, 40), 1'b1);
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          tick();
          desc_ready = 1'($urandom);
          rel = ($urandom_range(0, 7) == 0);
        end
      end
    join
    desc_ready = 1'b1;
    rel = 1'b0;
    repeat (10) tick();
    chk("rnd_writes_left", exp_wr.size(), 0);
    chk("rnd_descs_left", exp_desc.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
